// File: rtl/boxcar_interpolator.sv
// boxcar_interpolator: upsamples a signed stream by RATIO using a hold-then-ramp
// (linear) interpolator, with valid/ready handshakes on both sides.
// Optional build macro: BOXCAR_INTERP_ZOH_EN selects zero-order hold instead of
// linear interpolation. Handshake, FSM and reset behaviour are the same in both builds.
module boxcar_interpolator #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RATIO      = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_ce,
    output logic                         o_ready,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_ce,
    input  logic                         i_ready
);

    localparam int unsigned L  = $clog2(RATIO);
    localparam int unsigned SW = DATA_WIDTH + 1;
    localparam int unsigned AW = DATA_WIDTH + L + 1;

    localparam logic [0:0]   S_IDLE     = 1'b0;
    localparam logic [0:0]   S_RUN      = 1'b1;
    localparam logic [L-1:0] LAST_PHASE = L'(RATIO - 1);

    logic [0:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] cur_q,   cur_d;
    logic [SW-1:0]         step_q,  step_d;
    logic [AW-1:0]         acc_q,   acc_d;
    logic [L-1:0]          phase_q, phase_d;

    logic accept;
    logic beat;
    logic last_phase;

    // Handshake decode; o_ready is combinational so a new sample can land on the last beat
    assign last_phase = (phase_q == LAST_PHASE);
    assign o_ready    = (state_q == S_IDLE) || ((state_q == S_RUN) && last_phase && i_ready);
    assign accept     = i_ce && o_ready;
    assign o_ce       = (state_q == S_RUN);
    assign beat       = o_ce && i_ready;
    assign o_data     = acc_q[DATA_WIDTH+L-1:L];

    // Next-state and datapath update: reload on accept, ramp on each taken beat
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        step_d  = step_q;
        acc_d   = acc_q;
        phase_d = phase_q;

        if (accept) begin
`ifdef BOXCAR_INTERP_ZOH_EN
            // Hold the new sample for the whole segment
            step_d = '0;
            acc_d  = {i_data[DATA_WIDTH-1], i_data, {L{1'b0}}};
`else
            // Ramp from the previous sample toward the new one; one extra bit avoids overflow
            step_d = {i_data[DATA_WIDTH-1], i_data} - {cur_q[DATA_WIDTH-1], cur_q};
            acc_d  = {cur_q[DATA_WIDTH-1], cur_q, {L{1'b0}}};
`endif
            cur_d   = i_data;
            phase_d = '0;
            state_d = S_RUN;
        end else if ((state_q == S_RUN) && beat) begin
            if (!last_phase) begin
                acc_d   = acc_q + {{L{step_q[SW-1]}}, step_q};
                phase_d = phase_q + L'(1);
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // State and datapath registers with synchronous active-high reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            step_q  <= '0;
            acc_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: tb/tb_boxcar_interpolator.sv
// Testbench for boxcar_interpolator (DATA_WIDTH=8, RATIO=8): directed vector
// table for the named scenarios, then randomized traffic against a queue model.
// Define BOXCAR_INTERP_ZOH_EN for both files to exercise the zero-order-hold build.
module tb_boxcar_interpolator;

    localparam int DW    = 8;
    localparam int RATIO = 8;

    logic                 i_clk = 1'b0;
    logic                 i_reset;
    logic                 i_ce;
    logic                 o_ready;
    logic signed [DW-1:0] i_data;
    logic signed [DW-1:0] o_data;
    logic                 o_ce;
    logic                 i_ready;

    int n_checks = 0;
    int n_pass   = 0;

    boxcar_interpolator #(.DATA_WIDTH(DW), .RATIO(RATIO)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ce    (i_ce),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_data  (o_data),
        .o_ce    (o_ce),
        .i_ready (i_ready)
    );

    always #5 i_clk = ~i_clk;

    typedef int ramp_t [8];

    typedef struct {
        bit rst;
        bit ce;
        int din;
        bit rdy;
        bit chk;
        bit exp_ce;
        bit exp_rdy;
        bit chk_d;
        int exp_d;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic add_row(input bit rst, input bit ce, input int din, input bit rdy,
                           input bit chk, input bit exp_ce, input bit exp_rdy,
                           input bit chk_d, input int exp_d);
        vec_t v;
        v.rst = rst; v.ce = ce; v.din = din; v.rdy = rdy;
        v.chk = chk; v.exp_ce = exp_ce; v.exp_rdy = exp_rdy;
        v.chk_d = chk_d; v.exp_d = exp_d;
        vecs.push_back(v);
    endtask

    task automatic add_reset();
        add_row(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic add_idle_after_reset();
        add_row(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    endtask

    task automatic add_idle();
        add_row(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic add_accept(input int x);
        add_row(1'b0, 1'b1, x, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    endtask

    // Eight beats of a segment; from beat nxt_from on, the next sample is presented
    task automatic add_ramp(input ramp_t r, input int nxt_from, input int nxt);
        for (int k = 0; k < RATIO; k++) begin
            bit ce;
            ce = (k >= nxt_from);
            add_row(1'b0, ce, ce ? nxt : 0, 1'b1, 1'b1, 1'b1, (k == RATIO - 1), 1'b1, r[k]);
        end
    endtask

    function automatic ramp_t zoh(input int x);
        ramp_t r;
        for (int k = 0; k < RATIO; k++) r[k] = x;
        return r;
    endfunction

    function automatic int fdiv(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q--;
        return q;
    endfunction

    ramp_t r_0_64, r_64_0, r_0_m5, r_m5_127, r_127_m128, r_0_32;

    // Reference model state for the random phase
    int               exp_q[$];
    int               prev;
    bit               pending;
    logic signed [DW-1:0] pdata;

    initial begin
        i_reset = 1'b1;
        i_ce    = 1'b0;
        i_data  = '0;
        i_ready = 1'b1;

`ifdef BOXCAR_INTERP_ZOH_EN
        r_0_64     = zoh(64);
        r_64_0     = zoh(0);
        r_0_m5     = zoh(-5);
        r_m5_127   = zoh(127);
        r_127_m128 = zoh(-128);
        r_0_32     = zoh(32);
`else
        r_0_64     = '{0, 8, 16, 24, 32, 40, 48, 56};
        r_64_0     = '{64, 56, 48, 40, 32, 24, 16, 8};
        r_0_m5     = '{0, -1, -2, -2, -3, -4, -4, -5};
        r_m5_127   = '{-5, 11, 28, 44, 61, 77, 94, 110};
        r_127_m128 = '{127, 95, 63, 31, -1, -33, -65, -97};
        r_0_32     = '{0, 4, 8, 12, 16, 20, 24, 28};
`endif

        // Reset for two cycles, then idle with no beats
        add_reset();
        add_reset();
        add_idle_after_reset();
        add_idle_after_reset();
        // 0 -> 64 ramp, then 64 -> 0
        add_accept(64);
        add_ramp(r_0_64, RATIO, 0);
        add_idle();
        add_accept(0);
        add_ramp(r_64_0, RATIO, 0);
        add_idle();
        // Floor rounding on a negative ramp
        add_accept(-5);
        add_ramp(r_0_m5, RATIO, 0);
        add_idle();
        // Full-rate back-to-back segments across a full-scale step
        add_accept(127);
        add_ramp(r_m5_127, 5, -128);
        add_ramp(r_127_m128, RATIO, 0);
        add_idle();
        // Downstream stall of three cycles at phase 2
        add_reset();
        add_idle_after_reset();
        add_accept(64);
        for (int k = 0; k < RATIO; k++) begin
            if (k == 2)
                for (int s = 0; s < 3; s++)
                    add_row(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, r_0_64[2]);
            add_row(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1, (k == RATIO - 1), 1'b1, r_0_64[k]);
        end
        add_idle();
        // Reset at phase 4 of a ramp, then a fresh segment from 0
        add_reset();
        add_idle_after_reset();
        add_accept(64);
        for (int k = 0; k < 4; k++)
            add_row(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, r_0_64[k]);
        add_row(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, r_0_64[4]);
        add_idle_after_reset();
        add_accept(32);
        add_ramp(r_0_32, RATIO, 0);
        add_idle();

        @(posedge i_clk);
        #1;
        foreach (vecs[i]) begin
            i_reset = vecs[i].rst;
            i_ce    = vecs[i].ce;
            i_data  = DW'(vecs[i].din);
            i_ready = vecs[i].rdy;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("vec%0d o_ce", i), int'(o_ce), int'(vecs[i].exp_ce));
                check($sformatf("vec%0d o_ready", i), int'(o_ready), int'(vecs[i].exp_rdy));
            end
            if (vecs[i].chk_d)
                check($sformatf("vec%0d o_data", i), int'(o_data), vecs[i].exp_d);
            @(posedge i_clk);
            #1;
        end

        // Randomized traffic against the segment-queue model
        i_reset = 1'b1;
        i_ce    = 1'b0;
        @(posedge i_clk);
        #1;
        exp_q.delete();
        prev    = 0;
        pending = 1'b0;
        pdata   = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit m_ce, m_rdy, rst, rdy;
            rst = ($urandom_range(0, 499) == 0);
            if ((cyc / 250) % 2 == 0) rdy = 1'b1;
            else rdy = ($urandom_range(0, 3) != 0);
            if (!pending && ($urandom_range(0, 2) != 0)) begin
                pending = 1'b1;
                pdata   = DW'($urandom);
            end
            i_reset = rst;
            i_ready = rdy;
            i_ce    = pending;
            i_data  = pending ? pdata : DW'($urandom);
            #1;
            m_ce  = (exp_q.size() > 0);
            m_rdy = (exp_q.size() == 0) || ((exp_q.size() == 1) && rdy);
            check($sformatf("rnd%0d o_ce", cyc), int'(o_ce), int'(m_ce));
            check($sformatf("rnd%0d o_ready", cyc), int'(o_ready), int'(m_rdy));
            if (m_ce) check($sformatf("rnd%0d o_data", cyc), int'(o_data), exp_q[0]);
            if (rst) begin
                exp_q.delete();
                prev = 0;
            end else begin
                if (m_ce && rdy) void'(exp_q.pop_front());
                if (pending && m_rdy) begin
                    int x;
                    x = int'(pdata);
                    for (int k = 0; k < RATIO; k++) begin
`ifdef BOXCAR_INTERP_ZOH_EN
                        exp_q.push_back(x);
`else
                        exp_q.push_back(fdiv(prev * RATIO + k * (x - prev), RATIO));
`endif
                    end
                    prev    = x;
                    pending = 1'b0;
                end
            end
            @(posedge i_clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
